// File: rtl/dmem_wbuf_responder.sv
// dmem_wbuf_responder
//   Memory-side responder between the core's split read/write data-memory
//   ports and a single-port SRAM macro. Writes are queued in a small circular
//   write buffer and drained to the SRAM in cycles that carry no read. Reads
//   keep 1-cycle latency. Bytes still sitting in the buffer are forwarded
//   into the read data, so a read always sees every earlier write.
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   dmem_csb_write_i    write request (active-low), with wmask/waddr/din
//   dmem_csb_read_i     read request (active-low), with raddr
//   dmem_dout_o         read data, valid the cycle after accept, then held
//   dmem_stall_o        write buffer full; no request is accepted
//   sram_*_o            single-port SRAM command (csb/web active-low)
//   sram_dout_i         SRAM read data, valid the cycle after a read access
module dmem_wbuf_responder #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dmem_csb_write_i,
  input  logic [3:0]        dmem_wmask_i,
  input  logic [ADDR_W-1:0] dmem_waddr_i,
  input  logic [DATA_W-1:0] dmem_din_i,
  input  logic              dmem_csb_read_i,
  input  logic [ADDR_W-1:0] dmem_raddr_i,
  output logic [DATA_W-1:0] dmem_dout_o,
  output logic              dmem_stall_o,
  output logic              sram_csb_o,
  output logic              sram_web_o,
  output logic [3:0]        sram_wmask_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  localparam int PW = $clog2(WB_DEPTH);

  logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
  logic [3:0]        wb_mask_q [WB_DEPTH];

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PW:0]       count_q, count_d;
  logic              rd_pend_q;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [3:0]        fwd_mask_q, fwd_mask_d;
  logic [DATA_W-1:0] hold_q, merged;

  logic wr_acc, rd_acc, drain;

  assign dmem_stall_o = (count_q == (PW+1)'(WB_DEPTH));
  assign wr_acc = !dmem_csb_write_i && !dmem_stall_o && !reset_i;
  assign rd_acc = !dmem_csb_read_i && !dmem_stall_o && !reset_i;
  // A full buffer still drains, so a steady read stream cannot starve it.
  assign drain  = !reset_i && !rd_acc && (count_q != '0);

  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (rd_acc) begin
      sram_csb_o  = 1'b0;
      sram_addr_o = dmem_raddr_i;
    end else if (drain) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = 1'b0;
      sram_wmask_o = wb_mask_q[head_q];
      sram_addr_o  = wb_addr_q[head_q];
      sram_din_o   = wb_data_q[head_q];
    end
  end

  // Walk entries oldest to youngest so the youngest match per lane wins.
  // A write accepted this cycle is not yet in the array, so it is excluded.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_data_d = '0;
    fwd_mask_d = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (wb_addr_q[idx] == dmem_raddr_i)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_mask_q[idx][b]) begin
            fwd_data_d[8*b +: 8] = wb_data_q[idx][8*b +: 8];
            fwd_mask_d[b]        = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    merged = '0;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : sram_dout_i[8*b +: 8];
    end
  end

  assign dmem_dout_o = rd_pend_q ? merged : hold_q;

  always_comb begin
    head_d  = drain ? head_q + 1'b1 : head_q;
    tail_d  = wr_acc ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (wr_acc && !drain)      count_d = count_q + 1'b1;
    else if (!wr_acc && drain) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      hold_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_pend_q <= rd_acc;
      if (rd_acc) begin
        fwd_data_q <= fwd_data_d;
        fwd_mask_q <= fwd_mask_d;
      end
      if (rd_pend_q) hold_q <= merged;
    end
  end

  // Entry storage needs no reset: count gates every use of it.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      wb_addr_q[tail_q] <= dmem_waddr_i;
      wb_data_q[tail_q] <= dmem_din_i;
      wb_mask_q[tail_q] <= dmem_wmask_i;
    end
  end

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
module tb_dmem_wbuf_responder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dmem_csb_write_i;
  logic [3:0]  dmem_wmask_i;
  logic [7:0]  dmem_waddr_i;
  logic [31:0] dmem_din_i;
  logic        dmem_csb_read_i;
  logic [7:0]  dmem_raddr_i;
  logic [31:0] dmem_dout_o;
  logic        dmem_stall_o;
  logic        sram_csb_o;
  logic        sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_din_o;
  logic [31:0] sram_dout_i;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  dmem_wbuf_responder #(.ADDR_W(8), .DATA_W(32), .WB_DEPTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dmem_csb_write_i(dmem_csb_write_i), .dmem_wmask_i(dmem_wmask_i),
    .dmem_waddr_i(dmem_waddr_i), .dmem_din_i(dmem_din_i),
    .dmem_csb_read_i(dmem_csb_read_i), .dmem_raddr_i(dmem_raddr_i),
    .dmem_dout_o(dmem_dout_o), .dmem_stall_o(dmem_stall_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o),
    .sram_wmask_o(sram_wmask_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
  );

  // SRAM macro model: mem[i] = 0x5A0000ii, except 0x30 holds 0.
  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  int          sram_wr_cnt = 0;

  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 'h30) ? 32'h0 : (32'h5A00_0000 | 32'(i));
      mem_init    <= 1'b1;
      sram_dout_i <= '0;
    end else if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_din_o[8*b +: 8];
        sram_wr_cnt <= sram_wr_cnt + 1;
      end else begin
        sram_dout_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic wr, input logic [3:0] wm,
                       input logic [7:0] wa, input logic [31:0] wd,
                       input logic rd, input logic [7:0] ra);
    @(negedge clk_i);
    reset_i          = rst;
    dmem_csb_write_i = ~wr;
    dmem_wmask_i     = wm;
    dmem_waddr_i     = wa;
    dmem_din_i       = wd;
    dmem_csb_read_i  = ~rd;
    dmem_raddr_i     = ra;
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  wm;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [7:0]  ra;
    logic        e_stall;
    logic        e_csb;
    logic        e_web;
    logic [7:0]  e_addr;
    logic [3:0]  e_wm;
    logic [31:0] e_din;
    logic [31:0] e_dout;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [3:0] wm, logic [7:0] wa, logic [31:0] wd,
                              logic rd, logic [7:0] ra, logic e_stall, logic e_csb,
                              logic e_web, logic [7:0] e_addr, logic [3:0] e_wm,
                              logic [31:0] e_din, logic [31:0] e_dout);
    vec_t v;
    v.wr = wr; v.wm = wm; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
    v.e_stall = e_stall; v.e_csb = e_csb; v.e_web = e_web; v.e_addr = e_addr;
    v.e_wm = e_wm; v.e_din = e_din; v.e_dout = e_dout;
    return v;
  endfunction

  vec_t tbl [27];

  initial begin
    //            wr wm   wa     wd            rd ra     stl csb web addr   wm   din           dout
    // write then drain
    tbl[0]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  1,  1,  8'h00, 4'h0, 32'h0,        32'h0);
    tbl[1]  = mk(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 8'h00, 0,  1,  1,  8'h00, 4'h0, 32'h0,        32'h0);
    tbl[2]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h10, 4'hF, 32'hDEADBEEF, 32'h0);
    tbl[3]  = mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h10, 0,  0,  1,  8'h10, 4'h0, 32'h0,        32'h0);
    tbl[4]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  1,  1,  8'h00, 4'h0, 32'h0,        32'hDEADBEEF);
    // byte-merge forwarding under continuous reads
    tbl[5]  = mk(1, 4'hF, 8'h20, 32'h11223344, 1, 8'h00, 0,  0,  1,  8'h00, 4'h0, 32'h0,        32'hDEADBEEF);
    tbl[6]  = mk(1, 4'h1, 8'h20, 32'h000000AA, 1, 8'h00, 0,  0,  1,  8'h00, 4'h0, 32'h0,        32'h5A000000);
    tbl[7]  = mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h20, 0,  0,  1,  8'h20, 4'h0, 32'h0,        32'h5A000000);
    tbl[8]  = mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h00, 0,  0,  1,  8'h00, 4'h0, 32'h0,        32'h112233AA);
    tbl[9]  = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h20, 4'hF, 32'h11223344, 32'h5A000000);
    tbl[10] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h20, 4'h1, 32'h000000AA, 32'h5A000000);
    tbl[11] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  1,  1,  8'h00, 4'h0, 32'h0,        32'h5A000000);
    // fill, stall, held requests
    tbl[12] = mk(1, 4'hF, 8'h01, 32'h101,      1, 8'h20, 0,  0,  1,  8'h20, 4'h0, 32'h0,        32'h5A000000);
    tbl[13] = mk(1, 4'hF, 8'h02, 32'h102,      1, 8'h20, 0,  0,  1,  8'h20, 4'h0, 32'h0,        32'h112233AA);
    tbl[14] = mk(1, 4'hF, 8'h03, 32'h103,      1, 8'h20, 0,  0,  1,  8'h20, 4'h0, 32'h0,        32'h112233AA);
    tbl[15] = mk(1, 4'hF, 8'h04, 32'h104,      1, 8'h20, 0,  0,  1,  8'h20, 4'h0, 32'h0,        32'h112233AA);
    tbl[16] = mk(1, 4'hF, 8'h05, 32'h105,      1, 8'h04, 1,  0,  0,  8'h01, 4'hF, 32'h101,      32'h112233AA);
    tbl[17] = mk(1, 4'hF, 8'h05, 32'h105,      1, 8'h04, 0,  0,  1,  8'h04, 4'h0, 32'h0,        32'h112233AA);
    tbl[18] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 1,  0,  0,  8'h02, 4'hF, 32'h102,      32'h104);
    tbl[19] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h03, 4'hF, 32'h103,      32'h104);
    tbl[20] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h04, 4'hF, 32'h104,      32'h104);
    tbl[21] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h05, 4'hF, 32'h105,      32'h104);
    tbl[22] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  1,  1,  8'h00, 4'h0, 32'h0,        32'h104);
    // same-cycle read and write of one address
    tbl[23] = mk(1, 4'hF, 8'h30, 32'h55,       1, 8'h30, 0,  0,  1,  8'h30, 4'h0, 32'h0,        32'h104);
    tbl[24] = mk(0, 4'h0, 8'h00, 32'h0,        1, 8'h30, 0,  0,  1,  8'h30, 4'h0, 32'h0,        32'h0);
    tbl[25] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  0,  0,  8'h30, 4'hF, 32'h55,       32'h55);
    tbl[26] = mk(0, 4'h0, 8'h00, 32'h0,        0, 8'h00, 0,  1,  1,  8'h00, 4'h0, 32'h0,        32'h55);

    reset_i = 1'b1; dmem_csb_write_i = 1'b1; dmem_csb_read_i = 1'b1;
    dmem_wmask_i = '0; dmem_waddr_i = '0; dmem_din_i = '0; dmem_raddr_i = '0;
    repeat (2) @(posedge clk_i);

    drive(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    check("rst_stall", 32'(dmem_stall_o), 32'h0);
    check("rst_dout",  dmem_dout_o, 32'h0);
    check("rst_csb",   32'(sram_csb_o), 32'h1);
    check("rst_web",   32'(sram_web_o), 32'h1);
    check("rst_wmask", 32'(sram_wmask_o), 32'h0);
    check("rst_addr",  32'(sram_addr_o), 32'h0);
    check("rst_din",   sram_din_o, 32'h0);

    for (int i = 0; i < 27; i++) begin
      drive(0, tbl[i].wr, tbl[i].wm, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra);
      check($sformatf("v%0d_stall", i), 32'(dmem_stall_o), 32'(tbl[i].e_stall));
      check($sformatf("v%0d_csb", i),   32'(sram_csb_o),   32'(tbl[i].e_csb));
      check($sformatf("v%0d_web", i),   32'(sram_web_o),   32'(tbl[i].e_web));
      check($sformatf("v%0d_addr", i),  32'(sram_addr_o),  32'(tbl[i].e_addr));
      if (!(tbl[i].e_csb == 1'b0 && tbl[i].e_web == 1'b1)) begin
        check($sformatf("v%0d_wmask", i), 32'(sram_wmask_o), 32'(tbl[i].e_wm));
        check($sformatf("v%0d_din", i),   sram_din_o,        tbl[i].e_din);
      end
      check($sformatf("v%0d_dout", i), dmem_dout_o, tbl[i].e_dout);
    end

    // Reset with three writes still buffered: none may reach the SRAM.
    sram_wr_cnt = 0;
    drive(0, 1, 4'hF, 8'h40, 32'hBAD00040, 1, 8'h00);
    drive(0, 1, 4'hF, 8'h41, 32'hBAD00041, 1, 8'h00);
    drive(0, 1, 4'hF, 8'h42, 32'hBAD00042, 1, 8'h00);
    check("mid_nodrain_web", 32'(sram_web_o), 32'h1);
    drive(1, 1, 4'hF, 8'h43, 32'hBAD00043, 1, 8'h40);
    check("mid_rst_csb", 32'(sram_csb_o), 32'h1);
    check("mid_rst_web", 32'(sram_web_o), 32'h1);
    drive(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    check("mid_post_stall", 32'(dmem_stall_o), 32'h0);
    check("mid_post_csb",   32'(sram_csb_o), 32'h1);
    check("mid_post_dout",  dmem_dout_o, 32'h0);
    drive(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h40);
    drive(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h41);
    check("mid_rd40", dmem_dout_o, 32'h5A000040);
    drive(0, 0, 4'h0, 8'h00, 32'h0, 1, 8'h42);
    check("mid_rd41", dmem_dout_o, 32'h5A000041);
    drive(0, 0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
    check("mid_rd42", dmem_dout_o, 32'h5A000042);
    check("mid_csb_idle", 32'(sram_csb_o), 32'h1);
    @(posedge clk_i);
    #1;
    check("mid_sram_writes", 32'(sram_wr_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_wbuf_responder.md
# dmem_wbuf_responder

Memory-side responder for the core's data-memory interface. It accepts the core's split write-port/read-port requests and serves them from a single-port SRAM macro. Writes go into a small write buffer and drain to the SRAM in cycles with no read. Reads keep 1-cycle latency and forward bytes from buffered writes. It sits between `core` and a single-port dmem macro and replaces the dual-port dmem.

## Interface
Parameters:
- `ADDR_W`, 8, word address width.
- `DATA_W`, 32, data width; fixed at 32, with 4 byte lanes.
- `WB_DEPTH`, 4, write-buffer entries; must be a power of two, ≥2.

Ports:
- `clk_i`  in  1  clock; every register samples on the rising edge.
- `reset_i`  in  1  reset; synchronous and active-high.
- `dmem_csb_write_i`  in  1  write request, active-low.
- `dmem_wmask_i`  in  4  byte-lane write enables; bit i enables bits [8i+7:8i].
- `dmem_waddr_i`  in  ADDR_W  write word address.
- `dmem_din_i`  in  32  write data.
- `dmem_csb_read_i`  in  1  read request, active-low.
- `dmem_raddr_i`  in  ADDR_W  read word address.
- `dmem_dout_o`  out  32  read data, valid in cycle N+1 after a read accepted in cycle N, then held.
- `dmem_stall_o`  out  1  buffer full; no request is accepted this cycle.
- `sram_csb_o`  out  1  SRAM chip select, active-low.
- `sram_web_o`  out  1  SRAM write enable, active-low.
- `sram_wmask_o`  out  4  SRAM byte mask.
- `sram_addr_o`  out  ADDR_W  SRAM address.
- `sram_din_o`  out  32  SRAM write data.
- `sram_dout_i`  in  32  SRAM read data, valid in the cycle after a read access.

## Operation
- **Write buffer.** Circular FIFO of {addr, data, mask}, with head/tail pointers and a `count` of 0..WB_DEPTH. There is no coalescing.
- **Stall.** `dmem_stall_o` = (`count` == WB_DEPTH). It is combinational from registers only, and it blocks both reads and writes.
- **Write accept.** A write is accepted when `dmem_csb_write_i`=0, `dmem_stall_o`=0 and `reset_i`=0. The entry is pushed at the tail at the end of the cycle.
- **Read accept.** A read is accepted when `dmem_csb_read_i`=0, `dmem_stall_o`=0 and `reset_i`=0.
- **SRAM port priority** (combinational each cycle):
  1. Read accepted: `sram_csb_o`=0, `sram_web_o`=1, `sram_addr_o`=`dmem_raddr_i`.
  2. Otherwise, if `count`>0 (this includes the full case): drain the head. `sram_csb_o`=0, `sram_web_o`=0, and addr/din/wmask come from the head entry. The head is popped at the end of the cycle.
  3. Otherwise: `sram_csb_o`=1, `sram_web_o`=1, and addr/din/wmask are 0.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance.
- **Forwarding.**
  - At read-accept, each byte lane i takes the youngest valid buffer entry with addr == `dmem_raddr_i` and mask[i]=1.
  - The lane data and a forward-mask bit are registered as `fwd_data`/`fwd_mask`. Lanes with no match get `fwd_mask` bit 0.
  - The snapshot excludes a write accepted in the same cycle. A same-cycle read to the same address returns the pre-write value.
- **Read return.** A registered `rd_pend` flag is set for the cycle after a read is accepted.
  - While `rd_pend`=1: each lane of `dmem_dout_o` = `fwd_mask`[i] ? `fwd_data` lane : `sram_dout_i` lane. This merged value is also captured into `hold`.
  - While `rd_pend`=0: `dmem_dout_o` = `hold`.
- **Address width.** Addresses compare on the full ADDR_W bits. Pointers wrap modulo WB_DEPTH.
- **Reset.**
  - `count`, head, tail, `rd_pend`, `fwd_data`, `fwd_mask` and `hold` are all cleared to 0.
  - Reset mid-operation discards buffered writes; they never reach the SRAM.
  - While `reset_i`=1: `sram_csb_o`=1, `sram_web_o`=1, and no request is accepted.

## Timing
- **Reset values.** After the reset cycle: `dmem_stall_o`=0, `dmem_dout_o`=0, `sram_csb_o`=1, `sram_web_o`=1, `sram_wmask_o`=0, `sram_addr_o`=0, `sram_din_o`=0.
- **Read latency.** 1 cycle, request to `dmem_dout_o`, same as a raw SRAM macro.
- **Write to SRAM.** A write accepted in cycle N drains no earlier than N+1. It drains at the first cycle ≥ N+1 with no accepted read that has it at the head.
- **Write visibility.** A write accepted in cycle N is visible to reads accepted in cycle N+1 or later, through forwarding or through the SRAM.
- **Full buffer.** The drain is issued in the same cycle that `dmem_stall_o`=1. `dmem_stall_o` deasserts in the next cycle. Continuous reads therefore cannot starve the drain.
- **Held requests.** The core must hold a request while `dmem_stall_o`=1. The stalled request is accepted in the first cycle that `dmem_stall_o`=0.

## Test plan
1. **Reset.** Assert `reset_i` for 1 cycle → `dmem_stall_o`=0, `dmem_dout_o`=0, `sram_csb_o`=1, and `count`=0.
2. **Write then drain.** Write 0xDEADBEEF to 0x10 with mask 4'hF and no reads → next cycle the SRAM write has addr 0x10 and web=0. A read of 0x10 two cycles later returns 0xDEADBEEF.
3. **Byte-merge forwarding.** Reads to 0x00 every cycle, so nothing drains. Write 0x11223344 to 0x20 with mask F, then 0x000000AA to 0x20 with mask 1, then read 0x20 → `dmem_dout_o`=0x112233AA. No SRAM write is issued while reads continue.
4. **Full and stall.** Reads every cycle, and writes to 0x01..0x05 in consecutive cycles.
   - `dmem_stall_o`=1 in the cycle after the 4th write, and the 5th write is held.
   - A drain of 0x01 occurs that cycle, and `dmem_stall_o`=0 in the next cycle.
   - The 5th write is accepted and the held read is serviced.
5. **Same-cycle read and write.** 0x30 holds 0x0 in SRAM. Read and write (0x55, mask F) of 0x30 in the same cycle → the read returns 0x0. A read in the next cycle returns 0x55.
6. **Reset mid-operation.** Buffer 3 writes to 0x40..0x42 while reading, then reset → 0 SRAM write accesses occur. Reads of 0x40..0x42 after reset return the prior SRAM contents.
